// File: rtl/frame_pair_if.sv
// Handshake/bus bundle between frame_pair_streamer and its frame banks,
// control and the downstream gradient stage.
interface frame_pair_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_W      = 17
);
  logic                   start;
  logic                   curr_bank;
  logic                   busy;
  logic                   frame_done;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [PIXEL_WIDTH-1:0] rd_data_a;
  logic [PIXEL_WIDTH-1:0] rd_data_b;
  logic [PIXEL_WIDTH-1:0] pixel_curr;
  logic [PIXEL_WIDTH-1:0] pixel_prev;
  logic                   pixel_valid;

  modport master (
    input  start,
    input  curr_bank,
    input  rd_data_a,
    input  rd_data_b,
    output busy,
    output frame_done,
    output rd_en,
    output rd_addr,
    output pixel_curr,
    output pixel_prev,
    output pixel_valid
  );

  modport slave (
    output start,
    output curr_bank,
    output rd_data_a,
    output rd_data_b,
    input  busy,
    input  frame_done,
    input  rd_en,
    input  rd_addr,
    input  pixel_curr,
    input  pixel_prev,
    input  pixel_valid
  );
endinterface

// File: rtl/frame_pair_streamer.sv
// Raster-order reader of the current/previous frame banks; emits aligned
// pixel pairs with a fixed 2-cycle read latency and inter-line blanking.
module frame_pair_streamer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int H_BLANK     = 16,
  parameter int ADDR_W      = $clog2(WIDTH*HEIGHT)
) (
  input logic          clk,
  input logic          rst,
  frame_pair_if.master bus
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH-1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT-1);
  localparam logic [BW-1:0] B_LAST =
    BW'((H_BLANK > 0) ? H_BLANK-1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LINE  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]             state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [BW-1:0]          bcnt;
  logic [ADDR_W-1:0]      addr;
  logic                   bank;
  logic                   rd_en;
  logic                   last_rd;
  logic                   vld1;
  logic                   vld2;
  logic                   last1;
  logic                   done_q;
  logic [PIXEL_WIDTH-1:0] curr_q;
  logic [PIXEL_WIDTH-1:0] prev_q;

  assign rd_en   = (state == S_LINE);
  assign last_rd = rd_en && (x == X_LAST) && (y == Y_LAST);

  // addr is the read address itself: it only moves when a read is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      bcnt  <= '0;
      addr  <= '0;
      bank  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_LINE;
            bank  <= bus.curr_bank;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
          end
        end
        S_LINE: begin
          if (x == X_LAST) begin
            x <= '0;
            if (y == Y_LAST) begin
              state <= S_DRAIN;
            end else begin
              y <= y + 1'b1;
              if (H_BLANK > 0) begin
                state <= S_BLANK;
                bcnt  <= '0;
              end else begin
                addr <= addr + 1'b1;
              end
            end
          end else begin
            x    <= x + 1'b1;
            addr <= addr + 1'b1;
          end
        end
        S_BLANK: begin
          if (bcnt == B_LAST) begin
            state <= S_LINE;
            addr  <= addr + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (done_q) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // valid and last-pixel marker ride alongside the read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1   <= 1'b0;
      vld2   <= 1'b0;
      last1  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vld1   <= rd_en;
      vld2   <= vld1;
      last1  <= last_rd;
      done_q <= last1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_q <= '0;
      prev_q <= '0;
    end else if (vld1) begin
      if (bank) begin
        curr_q <= bus.rd_data_b;
        prev_q <= bus.rd_data_a;
      end else begin
        curr_q <= bus.rd_data_a;
        prev_q <= bus.rd_data_b;
      end
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.frame_done  = done_q;
  assign bus.rd_en       = rd_en;
  assign bus.rd_addr     = addr;
  assign bus.pixel_valid = vld2;
  assign bus.pixel_curr  = curr_q;
  assign bus.pixel_prev  = prev_q;

endmodule

// File: tb/tb_frame_pair_streamer.sv
// Directed bench: small 4x3 frames on two instances, plus a full default
// frame streamed concurrently on a third instance.
module tb_frame_pair_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_d;
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] VM2 = 32'h0003CF3C;
  localparam logic [31:0] RM2 = 32'h0000F3CF;
  localparam logic [31:0] DM2 = 32'h00020000;
  localparam logic [31:0] BM2 = 32'h0003FFFF;
  localparam logic [31:0] VM0 = 32'h00003FFC;
  localparam logic [31:0] RM0 = 32'h00000FFF;
  localparam logic [31:0] DM0 = 32'h00002000;
  localparam logic [31:0] BM0 = 32'h00003FFF;

  frame_pair_if #(.PIXEL_WIDTH(8), .ADDR_W(4))  ba ();
  frame_pair_if #(.PIXEL_WIDTH(8), .ADDR_W(4))  bz ();
  frame_pair_if #(.PIXEL_WIDTH(8), .ADDR_W(17)) bd ();

  frame_pair_streamer #(
    .PIXEL_WIDTH(8), .WIDTH(4), .HEIGHT(3), .H_BLANK(2), .ADDR_W(4)
  ) dut_a (.clk(clk), .rst(rst_s), .bus(ba.master));

  frame_pair_streamer #(
    .PIXEL_WIDTH(8), .WIDTH(4), .HEIGHT(3), .H_BLANK(0), .ADDR_W(4)
  ) dut_z (.clk(clk), .rst(rst_s), .bus(bz.master));

  frame_pair_streamer #(
    .PIXEL_WIDTH(8)
  ) dut_d (.clk(clk), .rst(rst_d), .bus(bd.master));

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];

  always @(posedge clk) begin
    if (ba.rd_en) begin
      ba.rd_data_a <= mem_a[ba.rd_addr];
      ba.rd_data_b <= mem_b[ba.rd_addr];
    end
    if (bz.rd_en) begin
      bz.rd_data_a <= mem_a[bz.rd_addr];
      bz.rd_data_b <= mem_b[bz.rd_addr];
    end
    if (bd.rd_en) begin
      bd.rd_data_a <= bd.rd_addr[7:0];
      bd.rd_data_b <= ~bd.rd_addr[7:0];
    end
  end

  logic sel;
  logic st;
  logic cb;
  logic st_d;
  assign ba.start     = st & ~sel;
  assign bz.start     = st & sel;
  assign ba.curr_bank = cb;
  assign bz.curr_bank = cb;
  assign bd.start     = st_d;
  assign bd.curr_bank = 1'b0;

  logic       s_valid, s_done, s_busy, s_rd_en;
  logic [7:0] s_curr, s_prev;
  logic [3:0] s_addr;
  always_comb begin
    s_valid = sel ? bz.pixel_valid : ba.pixel_valid;
    s_done  = sel ? bz.frame_done  : ba.frame_done;
    s_busy  = sel ? bz.busy        : ba.busy;
    s_rd_en = sel ? bz.rd_en       : ba.rd_en;
    s_curr  = sel ? bz.pixel_curr  : ba.pixel_curr;
    s_prev  = sel ? bz.pixel_prev  : ba.pixel_prev;
    s_addr  = sel ? bz.rd_addr     : ba.rd_addr;
  end

  // full-size frame monitor
  int          d_valids = 0;
  int          d_dones  = 0;
  int          d_bad    = 0;
  int          d_gaps   = 0;
  int          d_badgap = 0;
  int          d_gap    = 0;
  bit          d_inrun  = 0;
  bit          d_seen   = 0;
  logic [16:0] d_last   = '0;
  logic [7:0]  d_exp    = '0;

  always @(negedge clk) begin
    if (!rst_d) begin
      if (bd.pixel_valid) begin
        d_valids <= d_valids + 1;
        d_exp    <= d_exp + 8'd1;
        if (bd.pixel_curr !== d_exp || bd.pixel_prev !== ~d_exp)
          d_bad <= d_bad + 1;
      end
      if (bd.frame_done) d_dones <= d_dones + 1;
      if (bd.rd_en) begin
        d_last <= bd.rd_addr;
        if (d_inrun) begin
          d_gaps <= d_gaps + 1;
          if (d_gap != 16) d_badgap <= d_badgap + 1;
        end
        d_inrun <= 0;
        d_gap   <= 0;
        d_seen  <= 1;
      end else if (bd.busy && d_seen) begin
        d_inrun <= 1;
        d_gap   <= d_gap + 1;
      end
    end
  end

  logic [7:0] hc [2];
  logic [7:0] hp [2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_small(input bit z, input bit b,
                           input logic [31:0] vm, input logic [31:0] rm,
                           input logic [31:0] dm, input logic [31:0] bm,
                           input int ncyc, input bit poke);
    int k = 0;
    int r = 0;
    int h = z ? 1 : 0;
    sel = z;
    cb  = b;
    st  = 1'b1;
    step();
    st  = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      chk("rd_en", 32'(s_rd_en), 32'(rm[c]));
      if (rm[c]) begin
        chk("rd_addr", 32'(s_addr), r);
        r++;
      end
      chk("pixel_valid", 32'(s_valid), 32'(vm[c]));
      chk("frame_done", 32'(s_done), 32'(dm[c]));
      chk("busy", 32'(s_busy), 32'(bm[c]));
      if (vm[c]) begin
        hc[h] = b ? 8'(8'h80 + k) : 8'(k);
        hp[h] = b ? 8'(k) : 8'(8'h80 + k);
        k++;
      end
      chk("pixel_curr", 32'(s_curr), 32'(hc[h]));
      chk("pixel_prev", 32'(s_prev), 32'(hp[h]));
      if (c < ncyc - 1) begin
        st = poke && (c == 5 || c == 17);
        cb = poke ? ~b : b;
        step();
      end
    end
    st = 1'b0;
    cb = b;
  endtask

  initial begin
    rst_s = 1'b1;
    rst_d = 1'b1;
    st    = 1'b0;
    cb    = 1'b0;
    sel   = 1'b0;
    st_d  = 1'b0;
    hc[0] = '0; hc[1] = '0;
    hp[0] = '0; hp[1] = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'(8'h80 + i);
    end
    step();
    step();
    rst_s = 1'b0;
    rst_d = 1'b0;

    chk("rst_valid", 32'(ba.pixel_valid), 0);
    chk("rst_busy", 32'(ba.busy), 0);
    chk("rst_rd_en", 32'(ba.rd_en), 0);
    chk("rst_rd_addr", 32'(ba.rd_addr), 0);
    chk("rst_done", 32'(ba.frame_done), 0);
    chk("rst_curr", 32'(ba.pixel_curr), 0);

    st_d = 1'b1;
    step();
    st_d = 1'b0;

    // bank 0, blanking 2
    run_small(0, 0, VM2, RM2, DM2, BM2, 19, 0);
    // swapped banks
    run_small(0, 1, VM2, RM2, DM2, BM2, 19, 0);
    // no blanking
    run_small(1, 0, VM0, RM0, DM0, BM0, 15, 0);
    // ignored starts, then a back-to-back frame
    run_small(0, 0, VM2, RM2, DM2, BM2, 19, 1);
    run_small(0, 0, VM2, RM2, DM2, BM2, 19, 0);

    // reset after pixel 5
    sel = 1'b0;
    cb  = 1'b0;
    st  = 1'b1;
    step();
    st  = 1'b0;
    for (int c = 0; c < 9; c++) step();
    chk("pre_rst_valid", 32'(ba.pixel_valid), 1);
    chk("pre_rst_curr", 32'(ba.pixel_curr), 5);
    #2 rst_s = 1'b1;
    #1;
    chk("arst_valid", 32'(ba.pixel_valid), 0);
    chk("arst_curr", 32'(ba.pixel_curr), 0);
    chk("arst_prev", 32'(ba.pixel_prev), 0);
    chk("arst_busy", 32'(ba.busy), 0);
    chk("arst_done", 32'(ba.frame_done), 0);
    chk("arst_rd_en", 32'(ba.rd_en), 0);
    chk("arst_rd_addr", 32'(ba.rd_addr), 0);
    step();
    step();
    rst_s = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("post_rst_valid", 32'(ba.pixel_valid), 0);
      chk("post_rst_done", 32'(ba.frame_done), 0);
      step();
    end
    hc[0] = '0;
    hp[0] = '0;
    run_small(0, 0, VM2, RM2, DM2, BM2, 19, 0);

    // full default frame
    for (int i = 0; i < 100000 && d_dones == 0; i++) step();
    chk("d_done_seen", 32'(d_dones), 1);
    for (int i = 0; i < 8; i++) step();
    chk("d_valids", d_valids, 76800);
    chk("d_dones", d_dones, 1);
    chk("d_gaps", d_gaps, 239);
    chk("d_badgap", d_badgap, 0);
    chk("d_data_err", d_bad, 0);
    chk("d_last_addr", 32'(d_last), 76799);
    chk("d_busy_end", 32'(bd.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
